// File: rtl/gen_key_inv.sv
// Iterative AES-128 inverse key schedule: loaded with the round-10 key, it
// walks the schedule back to the cipher key, handing keys out over valid/ready.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = TBL[a];
endmodule

module gen_key_inv #(
    parameter bit EMIT_ALL = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] key_out,
    output logic [3:0]   round_out,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, RUN, PRESENT} state_t;
    state_t state;

    logic [31:0]  w0, w1, w2, w3, w1n, w2n, w3n, rot, sub, rcon;
    logic [7:0]   rc;
    logic [127:0] key_prev;

    // key_out doubles as the working register; the step is purely combinational
    assign {w0, w1, w2, w3} = key_out;
    assign w3n = w3 ^ w2;
    assign w2n = w2 ^ w1;
    assign w1n = w1 ^ w0;
    assign rot = {w3n[23:0], w3n[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a(rot[8*g +: 8]), .y(sub[8*g +: 8]));
    end

    always_comb begin
        rc = 8'h00;
        case (round_out)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
    end

    assign rcon     = {rc, 24'h0};
    assign key_prev = {w0 ^ sub ^ rcon, w1n, w2n, w3n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_out   <= '0;
            round_out <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_out   <= key_in;
                        round_out <= 4'd10;
                        busy      <= 1'b1;
                        if (EMIT_ALL) begin
                            state     <= PRESENT;
                            key_valid <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    key_out   <= key_prev;
                    round_out <= round_out - 4'd1;
                    if (round_out == 4'd1) begin
                        state     <= PRESENT;
                        key_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (key_ready) begin
                        if (round_out == 4'd0) begin
                            state     <= IDLE;
                            key_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            key_out   <= key_prev;
                            round_out <= round_out - 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/gen_key_inv.md
Name: gen_key_inv

Overview:
Iterative AES-128 inverse key schedule for the decryption datapath. It is loaded with the final (round-10) round key and walks the schedule backwards, producing one round key per accepted transfer, from round 10 down to round 0. Round 0 is the original cipher key. Output uses a valid/ready handshake so the inverse-cipher round engine can consume keys at its own pace without storing all 11 of them.

Parameters:
EMIT_ALL, 1, 1 = present every round key 10..0 on the output; 0 = iterate internally and present only the round-0 key.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  load request; sampled only in IDLE
key_in  input  128  round-10 key; word w0 = [127:96], byte 0 = [127:120]
key_out  output  128  current round key, registered
round_out  output  4  round index of key_out (10..0)
key_valid  output  1  key_out/round_out are valid
key_ready  input  1  consumer accepts key_out this cycle
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the round-0 key is accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE; key_out=0, round_out=0, key_valid=0, busy=0, done=0.
- States: IDLE, RUN (EMIT_ALL=0 only), PRESENT.
- IDLE and start=1 at edge N: register key_in and set round=10.
  - EMIT_ALL=1: go to PRESENT. key_valid=1 from N+1 with round_out=10.
  - EMIT_ALL=0: go to RUN.
- Backward step from round i key {w0,w1,w2,w3} to round i-1:
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon(i).
  - RotWord(x) = {x[23:0],x[31:24]}. SubWord = forward AES S-box on each byte.
  - Rcon(i) = {rc,24'h0}, where rc for i=1..10 is 01,02,04,08,10,20,40,80,1b,36.
  - The S-box is a combinational lookup inside the block: four instances, one step per cycle.
- PRESENT with key_valid=1:
  - key_ready=0: hold key_out, round_out and key_valid stable (no change while stalled).
  - key_ready=1 and round_out>0: next cycle key_out = previous round key, round_out decrements, key_valid stays 1. Back-to-back transfers at one key per cycle.
  - key_ready=1 and round_out==0: next cycle key_valid=0, done=1 for one cycle, busy=0, return to IDLE. key_out keeps the round-0 key.
- RUN (EMIT_ALL=0): one step per cycle, no handshake. After 10 steps (round reaches 0) go to PRESENT with key_valid=1 and round_out=0. Result is valid 11 cycles after start.
- start while busy: ignored, no reload. start on the same edge that done is asserted: ignored. It is accepted in IDLE on a later cycle.
- key_in is sampled only on the accepting edge and may change afterwards.
- Rcon for index 0 or 11..15 is 0. These indices are unreachable; no assertion is required.
- rst_n asserted mid-operation: immediate return to reset values. No done pulse; the partial sequence is discarded.

Test Plan:
- EMIT_ALL=1, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, start, key_ready=1 -> round 10 key equals key_in at N+1. Round 9 = ac7766f319fadc2128d12941575c006e. Round 1 = a0fafe1788542cb123a339392a6c7605. Round 0 = 2b7e151628aed2a6abf7158809cf4f3c at N+11. done at N+12.
- Same stimulus with key_ready toggled by a random pattern -> identical 11-key sequence. key_out/round_out stable whenever key_valid=1 and key_ready=0. No duplicated or skipped rounds.
- EMIT_ALL=0, same key_in -> single transfer, round_out=0, key_out=2b7e151628aed2a6abf7158809cf4f3c, key_valid first high 11 cycles after start.
- start pulsed repeatedly while busy with a different key_in -> sequence unaffected. Second start one cycle after done -> new sequence begins at round 10.
- rst_n pulled low asynchronously while round_out=5 -> all outputs 0 immediately, done never pulses. A subsequent start produces a correct full sequence.
- Compare against a software inverse key schedule for 1000 random round-10 keys -> every emitted key matches. Forward-expanding the round-0 result reproduces key_in.
